sim_bench: RTL and testbench

SIM_BENCH -- requirements
Module: sim_bench

---
 rtl/sim_bench_pkg.sv | 25 ++
 rtl/sim_bench_i2s_slave_tx.sv | 85 ++++++++
 rtl/sim_bench.sv | 106 ++++++++++
 tb/tb_sim_bench.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_bench_pkg.sv
// Shared constants and word-generation helper for the I2S loopback self-test.
package sim_bench_pkg;

    localparam int WORD_BITS   = 24;
    localparam int CHECK_WORDS = 32;
    localparam logic [WORD_BITS-1:0] PORT1_XOR = 24'h5A5A5A;
    localparam logic [7:0]           DONE_TAG  = 8'hB5;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

    // Left slot carries frame ^ mask, right slot carries its inverse.
    function automatic logic [WORD_BITS-1:0] chan_word(
        input logic [WORD_BITS-1:0] frame,
        input logic [WORD_BITS-1:0] mask,
        input chan_t                ch
    );
        logic [WORD_BITS-1:0] w;
        w = frame ^ mask;
        return (ch == CH_RIGHT) ? ~w : w;
    endfunction

endpackage

// File: rtl/sim_bench_i2s_slave_tx.sv
// I2S slave transmitter: input synchronizers, bit-clock edge detection,
// frame counter and MSB-first shifter; slot-start info is exported for a receiver.
module i2s_slave_tx
    import sim_bench_pkg::*;
#(
    parameter logic [WORD_BITS-1:0] XOR_MASK = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bclk,
    input  logic                 sync,
    output logic                 tx,
    output logic                 bclk_rise,
    output logic                 slot_start,
    output logic                 slot_valid,
    output logic [WORD_BITS-1:0] slot_word
);

    localparam logic [4:0] LAST_BIT = 5'(WORD_BITS);

    logic [2:0]           bclk_sr;
    logic [1:0]           sync_sr;
    logic                 bclk_fall;
    logic                 ws_q;
    chan_t                chan;
    logic                 armed;
    logic                 armed_nxt;
    logic [WORD_BITS-1:0] frame;
    logic [WORD_BITS-1:0] frame_nxt;
    logic [WORD_BITS-1:0] shreg;
    logic [4:0]           bit_cnt;

    assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
    assign bclk_fall = ~bclk_sr[1] & bclk_sr[2];
    // ws is latched on a rising edge, so the slot begins one bit after sync moves.
    assign slot_start = bclk_fall & (chan_t'(ws_q) != chan);

    always_comb begin
        frame_nxt = frame;
        armed_nxt = armed;
        if (slot_start && chan_t'(ws_q) == CH_LEFT) begin
            frame_nxt = frame + 24'd1;
            armed_nxt = 1'b1;
        end
        slot_valid = armed_nxt;
        slot_word  = armed_nxt ? chan_word(frame_nxt, XOR_MASK, chan_t'(ws_q)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bclk_sr <= '0;
            sync_sr <= '0;
            ws_q    <= 1'b0;
            chan    <= CH_LEFT;
            armed   <= 1'b0;
            frame   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
        end else begin
            bclk_sr <= {bclk_sr[1:0], bclk};
            sync_sr <= {sync_sr[0], sync};
            if (bclk_rise) begin
                ws_q <= sync_sr[1];
            end
            frame <= frame_nxt;
            armed <= armed_nxt;
            if (slot_start) begin
                chan    <= chan_t'(ws_q);
                tx      <= slot_word[WORD_BITS-1];
                shreg   <= {slot_word[WORD_BITS-2:0], 1'b0};
                bit_cnt <= 5'd1;
            end else if (bclk_fall) begin
                if (bit_cnt < LAST_BIT) begin
                    tx      <= shreg[WORD_BITS-1];
                    shreg   <= {shreg[WORD_BITS-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                end else begin
                    tx <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sim_bench.sv
// Two-port I2S slave self-test: both ports transmit frame-numbered words and
// port 0 checks its own looped-back data, reporting pass/fail and counts.
module sim_bench
    import sim_bench_pkg::*;
(
    input  logic        refclk,
    input  logic        rst,
    input  logic        i2s0_clk,
    input  logic        i2s0_sync,
    output logic        i2s0_tx,
    input  logic        i2s0_rx,
    input  logic        i2s1_clk,
    input  logic        i2s1_sync,
    output logic        i2s1_tx,
    output logic        sim_success,
    output logic        sim_done,
    output logic [31:0] sim_report
);

    localparam logic [4:0]  LAST_BIT = 5'(WORD_BITS);
    localparam logic [15:0] DONE_CNT = 16'(CHECK_WORDS);

    logic                 p0_rise;
    logic                 p0_start;
    logic                 p0_valid;
    logic [WORD_BITS-1:0] p0_word;
    logic                 p1_unused_rise;
    logic                 p1_unused_start;
    logic                 p1_unused_valid;
    logic [WORD_BITS-1:0] p1_unused_word;

    logic [1:0]           rx_sr;
    logic                 rx_valid;
    logic [WORD_BITS-1:0] rx_expect;
    logic [WORD_BITS-2:0] rx_shreg;
    logic [WORD_BITS-1:0] rx_word;
    logic [4:0]           rx_cnt;
    logic [15:0]          checked;
    logic [7:0]           errors;
    logic                 done;

    i2s_slave_tx #(.XOR_MASK('0)) u_port0 (
        .clk        (refclk),
        .rst        (rst),
        .bclk       (i2s0_clk),
        .sync       (i2s0_sync),
        .tx         (i2s0_tx),
        .bclk_rise  (p0_rise),
        .slot_start (p0_start),
        .slot_valid (p0_valid),
        .slot_word  (p0_word)
    );

    i2s_slave_tx #(.XOR_MASK(PORT1_XOR)) u_port1 (
        .clk        (refclk),
        .rst        (rst),
        .bclk       (i2s1_clk),
        .sync       (i2s1_sync),
        .tx         (i2s1_tx),
        .bclk_rise  (p1_unused_rise),
        .slot_start (p1_unused_start),
        .slot_valid (p1_unused_valid),
        .slot_word  (p1_unused_word)
    );

    // rx goes through the same two-flop depth as the bit clock, so edges and data line up.
    assign rx_word = {rx_shreg, rx_sr[1]};

    always_ff @(posedge refclk) begin
        if (!rst) begin
            rx_sr     <= '0;
            rx_valid  <= 1'b0;
            rx_expect <= '0;
            rx_shreg  <= '0;
            rx_cnt    <= '0;
            checked   <= '0;
            errors    <= '0;
            done      <= 1'b0;
        end else begin
            rx_sr <= {rx_sr[0], i2s0_rx};
            if (p0_start) begin
                rx_valid  <= p0_valid;
                rx_expect <= p0_word;
                rx_cnt    <= '0;
            end else if (p0_rise && rx_cnt < LAST_BIT) begin
                rx_shreg <= rx_word[WORD_BITS-2:0];
                rx_cnt   <= rx_cnt + 5'd1;
                // A slot is only judged once all 24 bits arrived before the next sync change.
                if (rx_cnt == LAST_BIT - 5'd1 && rx_valid && !done) begin
                    checked <= checked + 16'd1;
                    if (rx_word != rx_expect && errors != 8'hFF) begin
                        errors <= errors + 8'd1;
                    end
                    if (checked + 16'd1 == DONE_CNT) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

    assign sim_done    = done;
    assign sim_success = done & (errors == 8'd0);
    assign sim_report  = {done ? DONE_TAG : 8'h00, errors, checked};

endmodule

// File: tb/tb_sim_bench.sv
// Scoreboard bench: the stimulus pushes the words each port should send per slot,
// a bit-clock monitor reassembles both tx streams and compares them.
module tb_sim_bench;

    logic        refclk = 1'b0;
    logic        rst;
    logic        bclk;
    logic        sync;
    logic        loop_en;
    logic        rx_force;
    logic        i2s0_rx;
    logic        i2s0_tx;
    logic        i2s1_tx;
    logic        sim_success;
    logic        sim_done;
    logic [31:0] sim_report;

    int checks = 0;
    int errors = 0;
    int half_ns = 50;

    logic [23:0] q0[$];
    logic [23:0] q1[$];

    logic [23:0] m_frame;
    logic        m_armed;
    logic        m_chan;

    int          mon_cnt = 100;
    logic        mon_ws  = 1'b0;
    logic [23:0] mon_sr0 = '0;
    logic [23:0] mon_sr1 = '0;
    logic [23:0] last1 [2];

    always #5 refclk = ~refclk;

    assign i2s0_rx = loop_en ? i2s0_tx : rx_force;

    sim_bench dut (
        .refclk      (refclk),
        .rst         (rst),
        .i2s0_clk    (bclk),
        .i2s0_sync   (sync),
        .i2s0_tx     (i2s0_tx),
        .i2s0_rx     (i2s0_rx),
        .i2s1_clk    (bclk),
        .i2s1_sync   (sync),
        .i2s1_tx     (i2s1_tx),
        .sim_success (sim_success),
        .sim_done    (sim_done),
        .sim_report  (sim_report)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample at bit-clock rise; a sync change seen here ends the previous slot's LSB.
    always @(posedge bclk) begin
        logic [23:0] exp0;
        logic [23:0] exp1;
        mon_sr0 = {mon_sr0[22:0], i2s0_tx};
        mon_sr1 = {mon_sr1[22:0], i2s1_tx};
        mon_cnt++;
        if (mon_cnt == 24) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                check32("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd2);
            end else begin
                exp0 = q0.pop_front();
                exp1 = q1.pop_front();
                check32("port0_word", {8'h0, mon_sr0}, {8'h0, exp0});
                check32("port1_word", {8'h0, mon_sr1}, {8'h0, exp1});
            end
            last1[mon_ws] = mon_sr1;
        end
        if (sync !== mon_ws) begin
            mon_ws  = sync;
            mon_cnt = 0;
        end
    end

    task automatic bit_cycle();
        bclk = 1'b0;
        #(half_ns);
        bclk = 1'b1;
        #(half_ns);
    endtask

    task automatic model_slot(input logic ch, input int n);
        logic [23:0] w0;
        logic [23:0] w1;
        if (ch != m_chan) begin
            m_chan = ch;
            if (ch == 1'b0) begin
                m_frame = m_frame + 24'd1;
                m_armed = 1'b1;
            end
        end
        if (n >= 24) begin
            w0 = m_frame;
            w1 = m_frame ^ 24'h5A5A5A;
            if (ch) begin
                w0 = ~w0;
                w1 = ~w1;
            end
            q0.push_back(m_armed ? w0 : 24'h0);
            q1.push_back(m_armed ? w1 : 24'h0);
        end
    endtask

    // Hold sync at ch for n bit periods; optionally pulse reset during bit rst_at.
    task automatic slot(input logic ch, input int n, input int rst_at);
        model_slot(ch, n);
        sync = ch;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                bit_cycle();
                check32("midframe_reset_report", sim_report, 32'h0);
                check32("midframe_reset_flags", {28'h0, sim_done, sim_success, i2s0_tx, i2s1_tx}, 32'h0);
                rst = 1'b1;
                m_frame = '0;
                m_armed = 1'b0;
            end else begin
                bit_cycle();
            end
        end
    endtask

    task automatic start_test(input int h, input logic loop, input logic rxv);
        rst      = 1'b0;
        loop_en  = loop;
        rx_force = rxv;
        repeat (100) @(negedge refclk);
        check32("reset_report", sim_report, 32'h0);
        check32("reset_flags", {28'h0, sim_done, sim_success, i2s0_tx, i2s1_tx}, 32'h0);
        rst     = 1'b1;
        half_ns = h;
        m_frame = '0;
        m_armed = 1'b0;
        m_chan  = sync;
        @(posedge refclk);
        #2;
    endtask

    task automatic flush_and_settle();
        slot(1'b0, 2, -1);
        repeat (5) @(negedge refclk);
    endtask

    initial begin
        bclk     = 1'b1;
        sync     = 1'b0;
        rst      = 1'b0;
        loop_en  = 1'b1;
        rx_force = 1'b0;

        // Loopback at 130 ns half-period: 16 full frames reach done with no errors.
        start_test(130, 1'b1, 1'b0);
        slot(1'b1, 24, -1);
        for (int f = 1; f <= 16; f++) begin
            slot(1'b0, 24, -1);
            if (f == 2) begin
                check32("frame1_port1_left", {8'h0, last1[0]}, 32'h005A5A5B);
                check32("frame1_port1_right", {8'h0, last1[1]}, 32'h00A5A5A4);
            end
            slot(1'b1, 24, -1);
        end
        flush_and_settle();
        check32("loop_report", sim_report, 32'hB500_0020);
        check32("loop_flags", {30'h0, sim_done, sim_success}, 32'h3);

        // rx stuck high: every word mismatches; an extra frame after done changes nothing.
        start_test(50, 1'b0, 1'b1);
        slot(1'b1, 24, -1);
        for (int f = 1; f <= 17; f++) begin
            slot(1'b0, 24, -1);
            slot(1'b1, 24, -1);
        end
        flush_and_settle();
        check32("stuck_report", sim_report, 32'hB520_0020);
        check32("stuck_flags", {30'h0, sim_done, sim_success}, 32'h2);

        // Short left slot (10 bits) is dropped from the count.
        start_test(50, 1'b1, 1'b0);
        slot(1'b1, 24, -1);
        slot(1'b0, 24, -1);
        slot(1'b1, 24, -1);
        slot(1'b0, 10, -1);
        slot(1'b1, 24, -1);
        slot(1'b0, 24, -1);
        slot(1'b1, 24, -1);
        flush_and_settle();
        check32("discard_report", sim_report, 32'h0000_0005);

        // Reset pulse in the middle of a slot after five checked words.
        start_test(50, 1'b1, 1'b0);
        slot(1'b1, 24, -1);
        slot(1'b0, 24, -1);
        slot(1'b1, 24, -1);
        slot(1'b0, 24, -1);
        slot(1'b1, 24, -1);
        slot(1'b0, 24, -1);
        slot(1'b1, 4, -1);
        check32("before_reset_report", sim_report, 32'h0000_0005);
        slot(1'b1, 8, 2);
        slot(1'b0, 24, -1);
        slot(1'b1, 24, -1);
        slot(1'b0, 24, -1);
        slot(1'b1, 24, -1);
        flush_and_settle();
        check32("after_reset_report", sim_report, 32'h0000_0004);

        check32("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
